// File: rtl/seg7_readback.sv
// Seven-segment bus reader: waits for a stable {seg, dig} pattern, then decodes the
// segment lines back to a hex nibble and decimal point for the selected digit.
module seg7_readback #(
    parameter int unsigned NDIG           = 4,
    parameter bit          ACTIVE_LOW     = 1'b0,
    parameter bit          DIG_ACTIVE_LOW = 1'b0,
    parameter int unsigned STABLE         = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          seg,
    input  logic [NDIG-1:0]     dig,
    input  logic                clear,
    output logic [4*NDIG-1:0]   hex_out,
    output logic [NDIG-1:0]     dp_out,
    output logic [NDIG-1:0]     valid,
    output logic [NDIG-1:0]     err,
    output logic                upd
);

    typedef enum logic {StWait = 1'b0, StDone = 1'b1} state_e;

    localparam logic [7:0] StableCnt = 8'(STABLE);

    // Returns {hit, nibble}; hit is low for any pattern outside the encoder's table.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h27:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h58:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    logic [7:0]        s_in;
    logic [NDIG-1:0]   d_in;
    logic              changed;
    logic              capture;
    logic              one_hot;
    logic [3:0]        hot_cnt;
    logic [4:0]        dec;

    state_e            state_q, state_d;
    logic [7:0]        s1_q, s1_d;
    logic [NDIG-1:0]   d1_q, d1_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [4*NDIG-1:0] hex_q, hex_d;
    logic [NDIG-1:0]   dp_q, dp_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic [NDIG-1:0]   err_q, err_d;
    logic              upd_q, upd_d;

    always_comb begin
        s_in = ACTIVE_LOW ? ~seg : seg;
        d_in = DIG_ACTIVE_LOW ? ~dig : dig;
        changed = ({s_in, d_in} != {s1_q, d1_q});
        dec = decode_seg(s1_q[6:0]);

        hot_cnt = 4'd0;
        for (int i = 0; i < int'(NDIG); i++) begin
            hot_cnt = hot_cnt + 4'(d1_q[i]);
        end
        one_hot = (hot_cnt == 4'd1);
        capture = (state_q == StWait) && (cnt_q == StableCnt) && one_hot;

        state_d = state_q;
        s1_d    = s1_q;
        d1_d    = d1_q;
        cnt_d   = cnt_q;
        hex_d   = hex_q;
        dp_d    = dp_q;
        valid_d = valid_q;
        err_d   = err_q;
        upd_d   = 1'b0;

        if (changed) begin
            s1_d    = s_in;
            d1_d    = d_in;
            cnt_d   = 8'd1;
            state_d = StWait;
        end else if (cnt_q < StableCnt) begin
            cnt_d = cnt_q + 8'd1;
        end

        // A pattern change on the capture edge keeps WAIT so the new pattern still gets seen.
        if (capture) begin
            if (!changed) begin
                state_d = StDone;
            end
            upd_d = 1'b1;
            for (int i = 0; i < int'(NDIG); i++) begin
                if (d1_q[i]) begin
                    dp_d[i]    = s1_q[7];
                    valid_d[i] = 1'b1;
                    if (dec[4]) begin
                        hex_d[4*i +: 4] = dec[3:0];
                        err_d[i]        = 1'b0;
                    end else begin
                        err_d[i] = 1'b1;
                    end
                end
            end
        end

        // Clear wins over a coincident capture; the held sample is kept so it is recaptured.
        if (clear) begin
            hex_d   = '0;
            dp_d    = '0;
            valid_d = '0;
            err_d   = '0;
            upd_d   = 1'b0;
            cnt_d   = 8'd0;
            state_d = StWait;
            s1_d    = s1_q;
            d1_d    = d1_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StWait;
            s1_q    <= '0;
            d1_q    <= '0;
            cnt_q   <= '0;
            hex_q   <= '0;
            dp_q    <= '0;
            valid_q <= '0;
            err_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            d1_q    <= d1_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            upd_q   <= upd_d;
        end
    end

    assign hex_out = hex_q;
    assign dp_out  = dp_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign upd     = upd_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback: a table of encoder codes plus hand-written
// sequences for glitches, invalid patterns, active-low pins, reset and clear.
module tb_seg7_readback;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  dig;
    logic        clear;
    logic [15:0] hex_out;
    logic [3:0]  dp_out, valid, err;
    logic        upd;

    logic [7:0]  seg_al;
    logic [3:0]  dig_al;
    logic [15:0] hex_al;
    logic [3:0]  dp_al, valid_al, err_al;
    logic        upd_al;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seg7_readback #(.NDIG(4), .ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0), .STABLE(4)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig(dig), .clear(clear),
        .hex_out(hex_out), .dp_out(dp_out), .valid(valid), .err(err), .upd(upd)
    );

    seg7_readback #(.NDIG(4), .ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .STABLE(4)) dut_al (
        .clk(clk), .rst(rst), .seg(seg_al), .dig(dig_al), .clear(1'b0),
        .hex_out(hex_al), .dp_out(dp_al), .valid(valid_al), .err(err_al), .upd(upd_al)
    );

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] dig;
        logic [1:0] idx;
        logic [3:0] nib;
        logic       dp;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n, output int pulses);
        seg = s;
        dig = d;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (upd) pulses++;
        end
    endtask

    initial begin
        int p;
        int total;

        tbl[0]  = '{8'h3F, 4'b0001, 2'd0, 4'h0, 1'b0};
        tbl[1]  = '{8'h86, 4'b0010, 2'd1, 4'h1, 1'b1};
        tbl[2]  = '{8'h5B, 4'b0100, 2'd2, 4'h2, 1'b0};
        tbl[3]  = '{8'hCF, 4'b1000, 2'd3, 4'h3, 1'b1};
        tbl[4]  = '{8'h66, 4'b0001, 2'd0, 4'h4, 1'b0};
        tbl[5]  = '{8'hED, 4'b0010, 2'd1, 4'h5, 1'b1};
        tbl[6]  = '{8'h7D, 4'b0100, 2'd2, 4'h6, 1'b0};
        tbl[7]  = '{8'hA7, 4'b1000, 2'd3, 4'h7, 1'b1};
        tbl[8]  = '{8'h7F, 4'b0001, 2'd0, 4'h8, 1'b0};
        tbl[9]  = '{8'hEF, 4'b0010, 2'd1, 4'h9, 1'b1};
        tbl[10] = '{8'h77, 4'b0100, 2'd2, 4'hA, 1'b0};
        tbl[11] = '{8'hFC, 4'b1000, 2'd3, 4'hB, 1'b1};
        tbl[12] = '{8'h58, 4'b0001, 2'd0, 4'hC, 1'b0};
        tbl[13] = '{8'hDE, 4'b0010, 2'd1, 4'hD, 1'b1};
        tbl[14] = '{8'h79, 4'b0100, 2'd2, 4'hE, 1'b0};
        tbl[15] = '{8'hF1, 4'b1000, 2'd3, 4'hF, 1'b1};

        rst    = 1'b1;
        seg    = 8'h00;
        dig    = 4'b0000;
        clear  = 1'b0;
        seg_al = 8'hFF;
        dig_al = 4'hF;
        #3;
        check("reset hex_out", hex_out, 16'h0);
        check("reset dp_out", dp_out, 4'h0);
        check("reset valid", valid, 4'h0);
        check("reset err", err, 4'h0);
        check("reset upd", upd, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("idle no upd", upd, 1'b0);

        // Basic capture: update lands on the 5th edge after the change.
        seg = 8'h06;
        dig = 4'b0001;
        repeat (4) tick();
        check("basic upd before latency", upd, 1'b0);
        check("basic valid before latency", valid, 4'h0);
        tick();
        check("basic upd at 5th edge", upd, 1'b1);
        check("basic hex", hex_out[3:0], 4'h1);
        tick();
        check("basic upd one cycle", upd, 1'b0);
        hold(8'h06, 4'b0001, 4, p);
        check("basic no second upd", p, 0);
        check("basic valid", valid, 4'b0001);
        check("basic err", err, 4'b0000);

        // Round trip through all encoder codes.
        total = 0;
        for (int k = 0; k < 16; k++) begin
            hold(tbl[k].seg, tbl[k].dig, 6, p);
            total += p;
            check($sformatf("rt%0d upd count", k), p, 1);
            check($sformatf("rt%0d nibble", k), (hex_out >> (4 * tbl[k].idx)) & 16'hF, tbl[k].nib);
            check($sformatf("rt%0d dp", k), dp_out[tbl[k].idx], tbl[k].dp);
        end
        check("rt total upd", total, 16);
        check("rt hex_out", hex_out, 16'hFEDC);
        check("rt dp_out", dp_out, 4'b1010);
        check("rt valid", valid, 4'b1111);
        check("rt err", err, 4'b0000);

        // Clear with the last pattern held, then glitch before it can recapture.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear hex_out", hex_out, 16'h0);
        check("clear valid", valid, 4'h0);
        check("clear dp_out", dp_out, 4'h0);
        hold(8'h7F, 4'b0001, 3, p);
        check("glitch 7F no upd", p, 0);
        hold(8'h06, 4'b0001, 6, p);
        check("after glitch upd", p, 1);
        check("after glitch hex", hex_out[3:0], 4'h1);
        check("after glitch valid", valid, 4'b0001);
        hold(8'h06, 4'b0000, 20, p);
        check("dig zero no upd", p, 0);
        hold(8'h06, 4'b0011, 20, p);
        check("dig two-hot no upd", p, 0);
        check("select filter valid", valid, 4'b0001);

        // Invalid patterns keep the last good nibble.
        hold(8'h5B, 4'b0100, 6, p);
        check("inv good hex", hex_out[11:8], 4'h2);
        check("inv good err", err[2], 1'b0);
        hold(8'h49, 4'b0100, 6, p);
        check("inv 49 upd", p, 1);
        check("inv 49 hex", hex_out[11:8], 4'h2);
        check("inv 49 err", err[2], 1'b1);
        check("inv 49 valid", valid[2], 1'b1);
        hold(8'h00, 4'b0100, 6, p);
        check("inv blank upd", p, 1);
        check("inv blank hex", hex_out[11:8], 4'h2);
        check("inv blank err", err, 4'b0100);

        // Active-low pins on the second instance.
        seg_al = 8'h79;
        dig_al = 4'b1110;
        repeat (6) tick();
        check("al hex", hex_al[3:0], 4'h1);
        check("al dp", dp_al[0], 1'b1);
        check("al valid", valid_al, 4'b0001);
        check("al err", err_al, 4'b0000);

        // Asynchronous reset at cnt=2.
        seg = 8'h66;
        dig = 4'b0001;
        repeat (2) tick();
        #1 rst = 1'b1;
        #1;
        check("async rst hex_out", hex_out, 16'h0);
        check("async rst valid", valid, 4'h0);
        check("async rst err", err, 4'h0);
        check("async rst al valid", valid_al, 4'h0);
        #1 rst = 1'b0;
        repeat (4) tick();
        check("post-rst upd early", upd, 1'b0);
        tick();
        check("post-rst upd", upd, 1'b1);
        check("post-rst hex", hex_out[3:0], 4'h4);

        // Clear on the capture edge drops the capture, then recapture after the recount.
        seg = 8'h6D;
        dig = 4'b0001;
        repeat (4) tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear@cap upd", upd, 1'b0);
        check("clear@cap hex", hex_out, 16'h0);
        check("clear@cap valid", valid, 4'h0);
        repeat (4) tick();
        check("recap upd early", upd, 1'b0);
        tick();
        check("recap upd", upd, 1'b1);
        check("recap hex", hex_out[3:0], 4'h5);
        check("recap valid", valid, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
